// File: rtl/rule_set_intersect_pkg.sv
// Shared widths, types and helpers for the SIP/DIP rule-set intersect block.
package rule_set_intersect_pkg;

  localparam int NUM_RULE_ID      = 8;
  localparam int RULE_ID_WIDTH    = 3;
  localparam int RULE_ENTRY_WIDTH = 1 + RULE_ID_WIDTH;
  localparam int RULE_SET_WIDTH   = NUM_RULE_ID * RULE_ENTRY_WIDTH;
  localparam int FIFO_DEPTH       = 4;

  typedef logic [NUM_RULE_ID-1:0]    bitmap_t;
  typedef logic [RULE_SET_WIDTH-1:0] rule_set_t;
  typedef logic [RULE_ID_WIDTH-1:0]  rule_id_t;

  typedef struct packed {
    logic     vld;
    rule_id_t id;
  } rule_entry_t;

  function automatic bitmap_t set_to_bitmap(input rule_set_t s);
    bitmap_t     bm;
    rule_entry_t e;
    bm = '0;
    for (int i = 0; i < NUM_RULE_ID; i++) begin
      e = s[i*RULE_ENTRY_WIDTH +: RULE_ENTRY_WIDTH];
      if (e.vld) bm[e.id] = 1'b1;
    end
    return bm;
  endfunction

  // Scan high to low so the lowest set bit is written last and wins.
  function automatic rule_id_t lowest_id(input bitmap_t v);
    rule_id_t id;
    id = '0;
    for (int k = NUM_RULE_ID-1; k >= 0; k--) begin
      if (v[k]) id = rule_id_t'(k);
    end
    return id;
  endfunction

endpackage

// File: rtl/rule_set_intersect_if.sv
// Set inputs from the SIP/DIP trees and the intersect result bundle.
interface rule_set_intersect_if;
  import rule_set_intersect_pkg::*;

  logic      sip_set_valid;
  rule_set_t sip_set;
  logic      dip_set_valid;
  rule_set_t dip_set;
  logic      out_valid;
  logic      out_match;
  rule_id_t  out_rule_id;
  bitmap_t   out_match_vec;
  logic      sip_overflow;
  logic      dip_overflow;

  modport master (
    output sip_set_valid, sip_set,
    output dip_set_valid, dip_set,
    input  out_valid, out_match,
    input  out_rule_id, out_match_vec,
    input  sip_overflow, dip_overflow
  );

  modport slave (
    input  sip_set_valid, sip_set,
    input  dip_set_valid, dip_set,
    output out_valid, out_match,
    output out_rule_id, out_match_vec,
    output sip_overflow, dip_overflow
  );

endinterface

// File: rtl/rule_bitmap_fifo.sv
// Count-based sync FIFO for rule bitmaps with a sticky drop flag.
module rule_bitmap_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_empty,
  output logic             o_full,
  output logic             o_overflow
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             r_overflow;
  logic             w_pop;
  logic             w_push;

  assign o_empty    = (r_count == '0);
  assign o_full     = (r_count == (AW+1)'(DEPTH));
  assign o_dout     = r_mem[r_rd_ptr];
  assign o_overflow = r_overflow;

  // A full FIFO still takes a push when the head leaves that cycle.
  assign w_pop  = i_pop & ~o_empty;
  assign w_push = i_push & (~o_full | w_pop);

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push & ~w_pop)
        r_count <= r_count + 1'b1;
      else if (w_pop & ~w_push)
        r_count <= r_count - 1'b1;
      if (i_push & ~w_push) r_overflow <= 1'b1;
    end
  end

endmodule

// File: rtl/rule_set_intersect.sv
// Aligns SIP/DIP rule sets, intersects each pair, reports lowest rule ID.
module rule_set_intersect
  import rule_set_intersect_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  rule_set_intersect_if.slave  bus
);

  bitmap_t  w_sip_bm;
  bitmap_t  w_dip_bm;
  bitmap_t  w_sip_head;
  bitmap_t  w_dip_head;
  bitmap_t  w_vec;
  logic     w_sip_empty;
  logic     w_dip_empty;
  logic     w_sip_full;
  logic     w_dip_full;
  logic     w_sip_ovf;
  logic     w_dip_ovf;
  logic     w_pop;
  logic     w_unused;

  logic     r_valid;
  logic     r_match;
  rule_id_t r_rule_id;
  bitmap_t  r_vec;

  assign w_sip_bm = set_to_bitmap(bus.sip_set);
  assign w_dip_bm = set_to_bitmap(bus.dip_set);

  rule_bitmap_fifo #(
    .WIDTH (NUM_RULE_ID),
    .DEPTH (FIFO_DEPTH)
  ) u_sip_fifo (
    .clk        (clk),
    .reset      (reset),
    .i_push     (bus.sip_set_valid),
    .i_pop      (w_pop),
    .i_din      (w_sip_bm),
    .o_dout     (w_sip_head),
    .o_empty    (w_sip_empty),
    .o_full     (w_sip_full),
    .o_overflow (w_sip_ovf)
  );

  rule_bitmap_fifo #(
    .WIDTH (NUM_RULE_ID),
    .DEPTH (FIFO_DEPTH)
  ) u_dip_fifo (
    .clk        (clk),
    .reset      (reset),
    .i_push     (bus.dip_set_valid),
    .i_pop      (w_pop),
    .i_din      (w_dip_bm),
    .o_dout     (w_dip_head),
    .o_empty    (w_dip_empty),
    .o_full     (w_dip_full),
    .o_overflow (w_dip_ovf)
  );

  // Full is handled inside the FIFOs; the top only needs empty.
  assign w_unused = w_sip_full ^ w_dip_full;

  assign w_pop = ~w_sip_empty & ~w_dip_empty;
  assign w_vec = w_sip_head & w_dip_head;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid   <= 1'b0;
      r_match   <= 1'b0;
      r_rule_id <= '0;
      r_vec     <= '0;
    end else begin
      r_valid <= w_pop;
      if (w_pop) begin
        r_vec     <= w_vec;
        r_match   <= |w_vec;
        r_rule_id <= lowest_id(w_vec);
      end
    end
  end

  assign bus.out_valid     = r_valid;
  assign bus.out_match     = r_match;
  assign bus.out_rule_id   = r_rule_id;
  assign bus.out_match_vec = r_vec;
  assign bus.sip_overflow  = w_sip_ovf;
  assign bus.dip_overflow  = w_dip_ovf;

endmodule

// File: tb/tb_rule_set_intersect.sv
// Directed bench for rule_set_intersect: alignment, intersect, overflow, reset.
module tb_rule_set_intersect;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad = 0;

  rule_set_intersect_if bus();

  rule_set_intersect dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mk(input logic [7:0] bm);
    logic [31:0] r;
    logic [2:0]  id;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      id = i[2:0];
      r[4*i +: 4] = {bm[i], id};
    end
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_res(input string tag,
                         input logic [7:0] vec,
                         input logic [2:0] id);
    chk({tag, ".valid"}, 32'(bus.out_valid), 32'd1);
    chk({tag, ".vec"}, 32'(bus.out_match_vec), 32'(vec));
    chk({tag, ".match"}, 32'(bus.out_match), 32'(|vec));
    chk({tag, ".id"}, 32'(bus.out_rule_id), 32'(id));
  endtask

  logic [7:0] sv4 [4];
  logic [7:0] dv5 [5];

  initial begin
    bus.sip_set_valid = 1'b0;
    bus.sip_set       = '0;
    bus.dip_set_valid = 1'b0;
    bus.dip_set       = '0;
    sv4 = '{8'h01, 8'h02, 8'h04, 8'h08};
    dv5 = '{8'h81, 8'h82, 8'h84, 8'h88, 8'h90};

    // 1: reset for 3 cycles, idle afterwards
    repeat (3) step();
    reset = 1'b0;
    chk("rst.vec", 32'(bus.out_match_vec), 32'd0);
    chk("rst.match", 32'(bus.out_match), 32'd0);
    chk("rst.id", 32'(bus.out_rule_id), 32'd0);
    chk("rst.sovf", 32'(bus.sip_overflow), 32'd0);
    chk("rst.dovf", 32'(bus.dip_overflow), 32'd0);
    for (int c = 0; c < 4; c++) begin
      chk("idle.valid", 32'(bus.out_valid), 32'd0);
      step();
    end

    // 2: {1,3,5} & {3,5,7}, both at t
    bus.sip_set_valid = 1'b1;
    bus.sip_set       = mk(8'b0010_1010);
    bus.dip_set_valid = 1'b1;
    bus.dip_set       = mk(8'b1010_1000);
    step();
    bus.sip_set_valid = 1'b0;
    bus.dip_set_valid = 1'b0;
    chk("t2.lat1", 32'(bus.out_valid), 32'd0);
    step();
    chk_res("t2", 8'b0010_1000, 3'd3);
    step();
    chk("t2.pulse", 32'(bus.out_valid), 32'd0);
    chk("t2.hold", 32'(bus.out_match_vec), 32'h28);

    // 3: SIP {0} at t, DIP {6} at t+5
    bus.sip_set_valid = 1'b1;
    bus.sip_set       = mk(8'h01);
    step();
    bus.sip_set_valid = 1'b0;
    for (int c = 1; c < 5; c++) begin
      chk("t3.wait", 32'(bus.out_valid), 32'd0);
      step();
    end
    bus.dip_set_valid = 1'b1;
    bus.dip_set       = mk(8'h40);
    step();
    bus.dip_set_valid = 1'b0;
    chk("t3.t6", 32'(bus.out_valid), 32'd0);
    step();
    chk("t3.valid", 32'(bus.out_valid), 32'd1);
    chk("t3.vec", 32'(bus.out_match_vec), 32'd0);
    chk("t3.match", 32'(bus.out_match), 32'd0);
    chk("t3.id", 32'(bus.out_rule_id), 32'd0);
    step();

    // 4: six SIP sets, two dropped
    for (int k = 0; k < 6; k++) begin
      bus.sip_set_valid = 1'b1;
      bus.sip_set       = mk(8'(1 << k));
      step();
      if (k == 3) chk("t4.noovf", 32'(bus.sip_overflow), 32'd0);
    end
    bus.sip_set_valid = 1'b0;
    chk("t4.sovf", 32'(bus.sip_overflow), 32'd1);
    chk("t4.dovf", 32'(bus.dip_overflow), 32'd0);
    chk("t4.novalid", 32'(bus.out_valid), 32'd0);
    step();
    for (int c = 0; c < 7; c++) begin
      bus.dip_set_valid = (c < 4);
      bus.dip_set       = mk(8'hFF);
      if (c < 2)
        chk("t4.lat", 32'(bus.out_valid), 32'd0);
      else if (c < 6)
        chk_res("t4.res", sv4[c-2], 3'(c-2));
      else
        chk("t4.end", 32'(bus.out_valid), 32'd0);
      step();
    end
    chk("t4.sticky", 32'(bus.sip_overflow), 32'd1);

    // 5: invalid entry id 2 ignored, valid id 4 wins
    bus.sip_set_valid = 1'b1;
    bus.sip_set       = 32'h0000_00C2;
    bus.dip_set_valid = 1'b1;
    bus.dip_set       = 32'h0000_00C2;
    step();
    bus.sip_set       = 32'h0000_02CC;
    bus.dip_set       = 32'h0000_000C;
    step();
    bus.sip_set_valid = 1'b0;
    bus.dip_set_valid = 1'b0;
    chk_res("t5.inv", 8'h10, 3'd4);
    step();
    chk_res("t5.dup", 8'h10, 3'd4);
    step();
    chk("t5.end", 32'(bus.out_valid), 32'd0);

    // 6a: DIP full, push while popping is accepted
    for (int k = 0; k < 4; k++) begin
      bus.dip_set_valid = 1'b1;
      bus.dip_set       = mk(dv5[k]);
      step();
    end
    bus.dip_set_valid = 1'b0;
    bus.sip_set_valid = 1'b1;
    bus.sip_set       = mk(8'hFF);
    chk("t6.full.dovf", 32'(bus.dip_overflow), 32'd0);
    step();
    bus.sip_set_valid = 1'b0;
    bus.dip_set_valid = 1'b1;
    bus.dip_set       = mk(dv5[4]);
    chk("t6.nopop", 32'(bus.out_valid), 32'd0);
    step();
    bus.dip_set_valid = 1'b0;
    chk_res("t6.r0", dv5[0], 3'd0);
    chk("t6.dovf", 32'(bus.dip_overflow), 32'd0);
    step();
    for (int c = 0; c < 7; c++) begin
      bus.sip_set_valid = (c < 4);
      bus.sip_set       = mk(8'hFF);
      if (c < 2)
        chk("t6.lat", 32'(bus.out_valid), 32'd0);
      else if (c < 6)
        chk_res("t6.r", dv5[c-1], 3'(c-1));
      else
        chk("t6.end", 32'(bus.out_valid), 32'd0);
      step();
    end
    chk("t6.dovf2", 32'(bus.dip_overflow), 32'd0);

    // 6b: reset with two SIP sets buffered
    for (int k = 0; k < 2; k++) begin
      bus.sip_set_valid = 1'b1;
      bus.sip_set       = mk(8'h0F);
      step();
    end
    bus.sip_set_valid = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("t6.rst.sovf", 32'(bus.sip_overflow), 32'd0);
    chk("t6.rst.vec", 32'(bus.out_match_vec), 32'd0);
    chk("t6.rst.id", 32'(bus.out_rule_id), 32'd0);
    bus.dip_set_valid = 1'b1;
    bus.dip_set       = mk(8'hFF);
    step();
    bus.dip_set_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      chk("t6.stale", 32'(bus.out_valid), 32'd0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
